// File: rtl/project1_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : project1_sweep_checker
// Purpose  : Stimulus generator and response checker for a four-input
//            combinational function block (x1, x2, y1, y2 -> b).
//            A start request sweeps all 16 input vectors. Each vector is held
//            for SETTLE cycles. The returned b is then sampled in a single
//            SAMPLE cycle. The sampled bits build a truth table, which is
//            compared bit by bit against EXP_TT.
// Ports    : clk            - rising-edge clock
//            rst_n          - asynchronous active-low reset
//            start          - sweep request (honoured in IDLE or DONE only)
//            b_in           - response from the block under test
//            x1,y1,x2,y2    - stimulus = vector index bits 3,2,1,0
//            busy           - sweep in progress
//            done           - level, sweep complete until next start/reset
//            pass           - no mismatches (valid while done=1)
//            truth_table    - captured b, bit i = vector i
//            mismatch_cnt   - number of mismatching vectors (0..16)
//            first_fail_idx - lowest mismatching index (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module project1_sweep_checker #(
    parameter logic [15:0] EXP_TT = 16'h0000,
    parameter int unsigned SETTLE = 1          // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        b_in,
    output logic        x1,
    output logic        y1,
    output logic        x2,
    output logic        y2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_SETTLE   = SETTLE[3:0];
    localparam logic [3:0] c_LAST_IDX = 4'd15;
    localparam logic [4:0] c_MM_MAX   = 5'd16;

    state_t      state_q, state_d;
    logic [3:0]  idx_q,   idx_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [3:0]  stim_q,  stim_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        pass_q,  pass_d;
    logic [15:0] tt_q,    tt_d;
    logic [4:0]  mm_q,    mm_d;
    logic [3:0]  ffi_q,   ffi_d;

    logic        w_mismatch;
    logic [4:0]  w_mm_next;

    // Mismatch of the vector currently being sampled, and the count that
    // includes it. The count is used both for the register and for pass, so
    // the final vector is reflected in pass on the same edge.
    assign w_mismatch = (b_in != EXP_TT[idx_q]);
    assign w_mm_next  = (w_mismatch && (mm_q != c_MM_MAX)) ? (mm_q + 5'd1) : mm_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        ffi_d   = ffi_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 4'd0;
                    cnt_d   = c_SETTLE;
                    stim_d  = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    tt_d    = 16'h0000;
                    mm_d    = 5'd0;
                    ffi_d   = 4'd0;
                end
            end

            DRIVE: begin
                // The counter holds the remaining settle cycles including the
                // current one, so leaving on 1 gives exactly SETTLE cycles.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end

            SAMPLE: begin
                tt_d[idx_q] = b_in;
                mm_d        = w_mm_next;
                if (w_mismatch && (mm_q == 5'd0)) begin
                    ffi_d = idx_q;
                end
                if (idx_q == c_LAST_IDX) begin
                    state_d = DONE;
                    stim_d  = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (w_mm_next == 5'd0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 4'd1;
                    stim_d  = idx_q + 4'd1;
                    cnt_d   = c_SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            stim_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= 16'h0000;
            mm_q    <= 5'd0;
            ffi_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            ffi_q   <= ffi_d;
        end
    end

    assign x1             = stim_q[3];
    assign y1             = stim_q[2];
    assign x2             = stim_q[1];
    assign y2             = stim_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign truth_table    = tt_q;
    assign mismatch_cnt   = mm_q;
    assign first_fail_idx = ffi_q;

endmodule
`default_nettype wire

// File: tb/tb_project1_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_project1_sweep_checker
// Purpose  : Self-checking bench for project1_sweep_checker. Two instances:
//            u_a (SETTLE=1, EXP_TT=16'hBEEF) and u_b (SETTLE=3,
//            EXP_TT=16'hFFFF). The bench plays the function block. Each
//            sweep uses a response table. The expected results come from the
//            table alone: captured table = response table, mismatches = set
//            bits of (response ^ expected), first fail = lowest such bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_project1_sweep_checker;

    localparam logic [15:0] c_EXP_A    = 16'hBEEF;
    localparam int          c_SETTLE_A = 1;
    localparam logic [15:0] c_EXP_B    = 16'hFFFF;
    localparam int          c_SETTLE_B = 3;

    logic clk;
    logic rst_n;
    logic start_a, start_b;
    logic bin_a,   bin_b;

    logic        a_x1, a_y1, a_x2, a_y2, a_busy, a_done, a_pass;
    logic [15:0] a_tt;
    logic [4:0]  a_mm;
    logic [3:0]  a_ffi;
    logic        b_x1, b_y1, b_x2, b_y2, b_busy, b_done, b_pass;
    logic [15:0] b_tt;
    logic [4:0]  b_mm;
    logic [3:0]  b_ffi;

    int n_checks;
    int n_pass;

    // Snapshot of the selected instance's outputs
    logic [3:0]  o_stim;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_tt;
    logic [4:0]  o_mm;
    logic [3:0]  o_ffi;

    project1_sweep_checker #(.EXP_TT(c_EXP_A), .SETTLE(c_SETTLE_A)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .b_in(bin_a),
        .x1(a_x1), .y1(a_y1), .x2(a_x2), .y2(a_y2),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .truth_table(a_tt), .mismatch_cnt(a_mm), .first_fail_idx(a_ffi)
    );

    project1_sweep_checker #(.EXP_TT(c_EXP_B), .SETTLE(c_SETTLE_B)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .b_in(bin_b),
        .x1(b_x1), .y1(b_y1), .x2(b_x2), .y2(b_y2),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .truth_table(b_tt), .mismatch_cnt(b_mm), .first_fail_idx(b_ffi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic grab(input int sel);
        if (sel == 0) begin
            o_stim = {a_x1, a_y1, a_x2, a_y2};
            o_busy = a_busy; o_done = a_done; o_pass = a_pass;
            o_tt = a_tt; o_mm = a_mm; o_ffi = a_ffi;
        end else begin
            o_stim = {b_x1, b_y1, b_x2, b_y2};
            o_busy = b_busy; o_done = b_done; o_pass = b_pass;
            o_tt = b_tt; o_mm = b_mm; o_ffi = b_ffi;
        end
    endtask

    task automatic check_all_zero(input int sel, input string tag);
        grab(sel);
        check({tag, "_stim"}, 32'(o_stim), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_pass"}, 32'(o_pass), 32'd0);
        check({tag, "_tt"},   32'(o_tt),   32'd0);
        check({tag, "_mm"},   32'(o_mm),   32'd0);
        check({tag, "_ffi"},  32'(o_ffi),  32'd0);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_b(input int sel, input logic v);
        if (sel == 0) bin_a = v; else bin_b = v;
    endtask

    // Reference model: result of comparing a response table to an expected one
    task automatic ref_result(input logic [15:0] resp, input logic [15:0] exp_tt,
                              output int mm, output int ffi, output logic ok);
        logic [15:0] diff;
        diff = resp ^ exp_tt;
        mm   = $countones(diff);
        ffi  = 0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) ffi = i;
        end
        ok = (mm == 0);
    endtask

    // One sweep. Edge 0 is the edge that samples start. The block answers
    // with resp[observed vector]. When noisy, b_in is random during the settle
    // cycles and correct only in the cycle before each capture edge.
    // restart_edge >= 0 pulses start at that edge (must be ignored).
    task automatic run_sweep(input int sel, input int settle, input logic [15:0] exp_tt,
                             input logic [15:0] resp, input bit noisy,
                             input int restart_edge, input string tag);
        int   per, last, mm, ffi;
        logic ok;
        per  = settle + 1;
        last = 16 * per;
        ref_result(resp, exp_tt, mm, ffi, ok);

        @(posedge clk); #1;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        grab(sel);
        check({tag, "_clr_tt"},   32'(o_tt),   32'd0);
        check({tag, "_clr_mm"},   32'(o_mm),   32'd0);
        check({tag, "_clr_ffi"},  32'(o_ffi),  32'd0);
        check({tag, "_clr_done"}, 32'(o_done), 32'd0);
        check({tag, "_clr_pass"}, 32'(o_pass), 32'd0);

        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            grab(sel);
            if (k < last) begin
                check({tag, "_busy"}, 32'(o_busy), 32'd1);
                check({tag, "_done_early"}, 32'(o_done), 32'd0);
                check({tag, "_stim"}, 32'(o_stim), 32'(k / per));
                if (noisy && ((k % per) != settle))
                    set_b(sel, 1'($urandom_range(0, 1)));
                else
                    set_b(sel, resp[o_stim]);
                if (restart_edge >= 0 && k == restart_edge - 1) set_start(sel, 1'b1);
                if (restart_edge >= 0 && k == restart_edge)     set_start(sel, 1'b0);
            end else begin
                check({tag, "_done"}, 32'(o_done), 32'd1);
                check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
                check({tag, "_stim_end"}, 32'(o_stim), 32'd0);
                check({tag, "_tt"},   32'(o_tt),   32'(resp));
                check({tag, "_mm"},   32'(o_mm),   32'(mm));
                check({tag, "_ffi"},  32'(o_ffi),  32'(ffi));
                check({tag, "_pass"}, 32'(o_pass), 32'(ok));
            end
        end

        // Results must hold while idle in DONE
        repeat (3) @(posedge clk);
        #1;
        grab(sel);
        check({tag, "_hold_done"}, 32'(o_done), 32'd1);
        check({tag, "_hold_tt"},   32'(o_tt),   32'(resp));
        check({tag, "_hold_mm"},   32'(o_mm),   32'(mm));
        check({tag, "_hold_ffi"},  32'(o_ffi),  32'(ffi));
    endtask

    initial begin
        logic [15:0] r;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        bin_a    = 1'b0;
        bin_b    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero(0, "rst_a");
        check_all_zero(1, "rst_b");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of DRIVE at vector 5
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (10) begin
            bin_a = c_EXP_A[{a_x1, a_y1, a_x2, a_y2}];
            @(posedge clk);
        end
        #1;
        grab(0);
        check("midrst_pre_stim", 32'(o_stim), 32'd5);
        check("midrst_pre_busy", 32'(o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero(0, "postrst");

        // Golden sweep, then a single fault at vector 9 with an ignored start
        run_sweep(0, c_SETTLE_A, c_EXP_A, c_EXP_A, 1'b0, -1, "golden");
        run_sweep(0, c_SETTLE_A, c_EXP_A, c_EXP_A ^ 16'h0200, 1'b0, 10, "fault9");

        // Restarts from DONE with random response tables
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            run_sweep(0, c_SETTLE_A, c_EXP_A, r, 1'b0, ((i % 2) == 0) ? 7 : -1, "rand_a");
        end

        // SETTLE=3: stuck-at-0, golden, random, with b_in noise in settle cycles
        run_sweep(1, c_SETTLE_B, c_EXP_B, 16'h0000, 1'b1, -1, "stuck0");
        run_sweep(1, c_SETTLE_B, c_EXP_B, c_EXP_B, 1'b1, 20, "golden_b");
        for (int i = 0; i < 2; i++) begin
            r = 16'($urandom);
            run_sweep(1, c_SETTLE_B, c_EXP_B, r, 1'b1, -1, "rand_b");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: got no-finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/project1_sweep_checker.md
Name: project1_sweep_checker

Overview:
- Sequential stimulus generator and response checker for the Project 1 four-input combinational function blocks (inputs x1, x2, y1, y2; single output b).
- On a start request it drives all 16 input combinations, waits a programmable settle time per vector, and samples the returned b.
- It assembles the sampled bits into a 16-bit truth table and compares each bit against an expected table.
- It sits on the initiator side of the function block and reports pass/fail, mismatch count and first failing index.

Parameters:
- EXP_TT, 16'h0000, expected truth table; bit i is the expected b for vector index i.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request, sampled on clk; honoured only in IDLE or DONE.
- b_in  input  1  response b from the function block under test.
- x1  output  1  stimulus; equals vector index bit 3.
- y1  output  1  stimulus; equals vector index bit 2.
- x2  output  1  stimulus; equals vector index bit 1.
- y2  output  1  stimulus; equals vector index bit 0.
- busy  output  1  high while the sweep is in progress.
- done  output  1  level; high from sweep completion until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff mismatch_cnt==0.
- truth_table  output  16  captured b values, bit i = vector i.
- mismatch_cnt  output  5  number of mismatching vectors, 0..16.
- first_fail_idx  output  4  lowest mismatching index; 0 when there is no mismatch.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset value of every output is 0: x1, y1, x2, y2, busy, done, pass, truth_table, mismatch_cnt, first_fail_idx. State resets to IDLE.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - idx<=0; truth_table, mismatch_cnt, first_fail_idx, done and pass cleared.
  - busy<=1; next state DRIVE; settle counter loaded with SETTLE.
- DRIVE:
  - Stimulus outputs = idx.
  - The counter decrements each edge. The state moves to SAMPLE on the edge where the count reaches 0, so DRIVE lasts exactly SETTLE cycles.
- SAMPLE (exactly one cycle):
  - truth_table[idx]<=b_in.
  - If b_in!=EXP_TT[idx]: mismatch_cnt<=mismatch_cnt+1, saturating at 16. If this is the first mismatch of the sweep, first_fail_idx<=idx.
  - If idx==15: next state DONE; busy<=0; done<=1; pass computed including the current vector.
  - Otherwise idx<=idx+1 (no wrap needed), reload the counter, next state DRIVE.
- Per-vector cost is SETTLE+1 cycles. Counting the start-sampling edge as edge 0, done rises on edge 16*(SETTLE+1); with SETTLE=1 that is edge 32.
- Stimulus outputs are 0 in IDLE and DONE. They change only on entry to DRIVE.
- start while busy=1 is ignored; it causes no restart and no effect.
- start held high in DONE restarts the sweep every time it is sampled there.
- Reset mid-sweep asynchronously returns the block to IDLE with all outputs 0. No partial results are retained.
- The truth_table, mismatch_cnt and first_fail_idx results hold stable in DONE until the next accepted start.

Test Plan:
- Reset values: assert rst_n=0 mid-DRIVE at idx=5 -> all outputs 0 immediately (asynchronous), state IDLE; no activity until start.
- Golden sweep: SETTLE=1, EXP_TT=16'hBEEF, bench models b_in=EXP_TT[{x1,y1,x2,y2}] -> done on edge 32, truth_table=16'hBEEF, mismatch_cnt=0, pass=1, first_fail_idx=0.
- Stuck-at-0 response: EXP_TT=16'hFFFF, b_in tied 0 -> truth_table=16'h0000, mismatch_cnt=16, pass=0, first_fail_idx=0.
- Single fault: EXP_TT=16'hBEEF, model flips only vector 9 -> mismatch_cnt=1, first_fail_idx=9, truth_table=16'hBCEF, pass=0.
- Handshake: pulse start again at edge 10 of a sweep -> ignored, done still on edge 32. Then start in DONE -> results cleared next edge, busy=1, new sweep completes 32 edges later.
- Timing: SETTLE=3 -> each stimulus value held 3 cycles plus 1 sample cycle; done on edge 64; b_in toggled during settle cycles has no effect on capture.
